// File: rtl/lcd_rgb_capture_pkg.sv
// Shared widths, lock-state encoding and measured-timing record for the LCD RGB capture block.
package lcd_rgb_capture_pkg;

    localparam int CNT_W = 12;
    localparam int R_W   = 5;
    localparam int G_W   = 6;
    localparam int B_W   = 5;
    localparam int RGB_W = R_W + G_W + B_W;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_VERIFY  = 2'd2,
        ST_LOCKED  = 2'd3
    } lock_state_t;

    typedef struct packed {
        logic [CNT_W-1:0] h_active;
        logic [CNT_W-1:0] h_total;
        logic [CNT_W-1:0] v_active;
        logic [CNT_W-1:0] v_total;
    } timing_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

endpackage

// File: rtl/lcd_sync_edge.sv
// Input register stage: syncs normalised to active-high, then leading/falling edge detection.
module lcd_sync_edge
    import lcd_rgb_capture_pkg::*;
#(
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lcd_de,
    input  logic             lcd_hsync,
    input  logic             lcd_vsync,
    input  logic [RGB_W-1:0] lcd_rgb,
    output logic             de,
    output logic [RGB_W-1:0] rgb,
    output logic             de_rise,
    output logic             de_fall,
    output logic             hs_lead,
    output logic             vs_lead
);

    logic hs;
    logic vs;
    logic de_d;
    logic hs_d;
    logic vs_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de   <= 1'b0;
            hs   <= 1'b0;
            vs   <= 1'b0;
            rgb  <= '0;
            de_d <= 1'b0;
            hs_d <= 1'b0;
            vs_d <= 1'b0;
        end else begin
            de   <= lcd_de;
            hs   <= lcd_hsync ^ SYNC_ACTIVE_LOW;
            vs   <= lcd_vsync ^ SYNC_ACTIVE_LOW;
            rgb  <= lcd_rgb;
            de_d <= de;
            hs_d <= hs;
            vs_d <= vs;
        end
    end

    assign de_rise = de & ~de_d;
    assign de_fall = ~de & de_d;
    assign hs_lead = hs & ~hs_d;
    assign vs_lead = vs & ~vs_d;

endmodule

// File: rtl/lcd_rgb_capture.sv
// RGB565 LCD capture: pixel coordinates, per-frame timing measurement and lock tracking.
//   state   | meaning
//   SEARCH  | no frame reference, waiting for a VSYNC leading edge
//   MEASURE | first frame being measured
//   VERIFY  | candidate held, waiting for a frame that repeats it
//   LOCKED  | timing stable; a differing frame raises fmt_err
module lcd_rgb_capture
    import lcd_rgb_capture_pkg::*;
#(
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int TIMEOUT_LOG2    = 20
) (
    input  logic             PixelClk,
    input  logic             RST,
    input  logic             LCD_DE,
    input  logic             LCD_HSYNC,
    input  logic             LCD_VSYNC,
    input  logic [R_W-1:0]   LCD_R,
    input  logic [G_W-1:0]   LCD_G,
    input  logic [B_W-1:0]   LCD_B,
    output logic             pix_valid,
    output logic [RGB_W-1:0] pix_rgb,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             frame_start,
    output logic             line_start,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] v_active,
    output logic [CNT_W-1:0] v_total,
    output logic             locked,
    output logic             fmt_err
);

    logic             de;
    logic [RGB_W-1:0] rgb;
    logic             de_rise;
    logic             de_fall;
    logic             hs_lead;
    logic             vs_lead;

    lcd_sync_edge #(
        .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)
    ) u_sync_edge (
        .clk      (PixelClk),
        .rst      (RST),
        .lcd_de   (LCD_DE),
        .lcd_hsync(LCD_HSYNC),
        .lcd_vsync(LCD_VSYNC),
        .lcd_rgb  ({LCD_R, LCD_G, LCD_B}),
        .de       (de),
        .rgb      (rgb),
        .de_rise  (de_rise),
        .de_fall  (de_fall),
        .hs_lead  (hs_lead),
        .vs_lead  (vs_lead)
    );

    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            pix_valid   <= 1'b0;
            pix_rgb     <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            pix_valid   <= de;
            pix_rgb     <= rgb;
            frame_start <= vs_lead;
            line_start  <= hs_lead;
            if (de_rise) begin
                pix_x <= '0;
            end else if (de) begin
                pix_x <= sat_inc(pix_x);
            end
            if (vs_lead) begin
                pix_y <= '0;
            end else if (de_fall) begin
                pix_y <= sat_inc(pix_y);
            end
        end
    end

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] h_last;
    logic [CNT_W-1:0] de_cnt;
    logic [CNT_W-1:0] de_last;
    logic [CNT_W-1:0] v_cnt;
    logic [CNT_W-1:0] v_de;

    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            h_cnt   <= '0;
            h_last  <= '0;
            de_cnt  <= '0;
            de_last <= '0;
            v_cnt   <= '0;
            v_de    <= '0;
        end else begin
            if (hs_lead) begin
                h_last <= h_cnt;
                h_cnt  <= CNT_ONE;
            end else begin
                h_cnt <= sat_inc(h_cnt);
            end
            if (de_rise) begin
                de_cnt <= CNT_ONE;
            end else if (de) begin
                de_cnt <= sat_inc(de_cnt);
            end
            if (vs_lead) begin
                de_last <= '0;
                v_cnt   <= '0;
                v_de    <= '0;
            end else begin
                if (de_fall) begin
                    de_last <= de_cnt;
                    v_de    <= sat_inc(v_de);
                end
                if (hs_lead) begin
                    v_cnt <= sat_inc(v_cnt);
                end
            end
        end
    end

    // Edges coinciding with VSYNC still belong to the frame being closed.
    timing_t meas;
    always_comb begin
        meas.h_total  = hs_lead ? h_cnt : h_last;
        meas.h_active = de_fall ? de_cnt : de_last;
        meas.v_total  = hs_lead ? sat_inc(v_cnt) : v_cnt;
        meas.v_active = de_fall ? sat_inc(v_de) : v_de;
    end

    logic [TIMEOUT_LOG2-1:0] to_cnt;
    logic                    timeout;

    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            to_cnt <= '0;
        end else if (vs_lead) begin
            to_cnt <= '1;
        end else if (to_cnt != '0) begin
            to_cnt <= to_cnt - TIMEOUT_LOG2'(1);
        end
    end

    assign timeout = (to_cnt == '0) && !vs_lead;

    lock_state_t state;
    lock_state_t state_nxt;
    timing_t     cand;
    logic        same;
    logic        cand_load;
    logic        fmt_set;

    assign same = (meas == cand);

    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            state <= ST_SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_SEARCH:  if (vs_lead)          state_nxt = ST_MEASURE;
            ST_MEASURE: if (vs_lead)          state_nxt = ST_VERIFY;
            ST_VERIFY:  if (vs_lead && same)  state_nxt = ST_LOCKED;
            ST_LOCKED:  if (vs_lead && !same) state_nxt = ST_VERIFY;
            default:                          state_nxt = ST_SEARCH;
        endcase
        if (timeout) begin
            state_nxt = ST_SEARCH;
        end
    end

    always_comb begin
        locked    = (state == ST_LOCKED);
        cand_load = vs_lead && (state != ST_SEARCH);
        fmt_set   = vs_lead && (state == ST_LOCKED) && !same;
    end

    // The published measurements double as the lock candidate.
    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            cand    <= '0;
            fmt_err <= 1'b0;
        end else begin
            fmt_err <= fmt_set;
            if (cand_load) begin
                cand <= meas;
            end
        end
    end

    assign h_active = cand.h_active;
    assign h_total  = cand.h_total;
    assign v_active = cand.v_active;
    assign v_total  = cand.v_total;

endmodule

// File: doc/lcd_rgb_capture.md
LCD_RGB_CAPTURE -- requirements
Module: lcd_rgb_capture

Interface
REQ-001 Parameter SYNC_ACTIVE_LOW, default 1, meaning: 1 = LCD_HSYNC/LCD_VSYNC asserted low, 0 = asserted high.
REQ-002 Parameter TIMEOUT_LOG2, default 20, meaning: no VSYNC leading edge for 2^TIMEOUT_LOG2 clocks forces loss of lock.
REQ-003 PixelClk  in  1  the single clock; all inputs are sampled and all outputs are driven on its rising edge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 LCD_DE  in  1  data enable from the RGB source.
REQ-006 LCD_HSYNC  in  1  horizontal sync.
REQ-007 LCD_VSYNC  in  1  vertical sync.
REQ-008 LCD_R  in  5 / LCD_G  in  6 / LCD_B  in  5  RGB565 pixel data.
REQ-009 pix_valid  out  1  captured pixel is valid this cycle.
REQ-010 pix_rgb  out  16  captured pixel as {R,G,B}.
REQ-011 pix_x  out  12 / pix_y  out  12  pixel column and row within the active area.
REQ-012 frame_start  out  1  one-cycle pulse on a VSYNC leading edge.
REQ-013 line_start  out  1  one-cycle pulse on an HSYNC leading edge.
REQ-014 h_active, h_total, v_active, v_total  out  12 each  timing values measured on the last complete frame.
REQ-015 locked  out  1  source timing is stable.
REQ-016 fmt_err  out  1  one-cycle pulse when timing changes while locked.

Function
REQ-017 All inputs SHALL pass through one register stage; leading edges are detected on the registered values and the active level is set by SYNC_ACTIVE_LOW.
REQ-018 Pixel path latency SHALL be exactly 2 clocks from input pins to pix_valid/pix_rgb/pix_x/pix_y.
REQ-019 pix_x SHALL be 0 on the first DE-high cycle of a line, increment by 1 per DE-high cycle, and restart at 0 on the next DE rising edge.
REQ-020 pix_y SHALL be 0 for the first DE line after a VSYNC leading edge and increment by 1 on each DE falling edge.
REQ-021 Counters SHALL saturate at 4095 and never wrap.
REQ-022 h_total SHALL be the clock count between consecutive HSYNC leading edges.
REQ-023 h_active SHALL be the DE-high clock count of the last DE line in the frame.
REQ-024 v_total SHALL be the number of HSYNC leading edges between consecutive VSYNC leading edges.
REQ-025 v_active SHALL be the number of DE lines between consecutive VSYNC leading edges.
REQ-026 The four measured values SHALL update together, only on a VSYNC leading edge that closes a complete frame.
REQ-027 Lock FSM states: SEARCH, MEASURE, VERIFY, LOCKED.
- SEARCH to MEASURE on a VSYNC leading edge.
- MEASURE to VERIFY on the next VSYNC leading edge; the measured values are latched as the candidate.
REQ-028 VERIFY transitions on each VSYNC leading edge:
- new values equal to the candidate: go to LOCKED.
- new values differ: replace the candidate and stay in VERIFY.
REQ-029 LOCKED transitions on each VSYNC leading edge:
- new values differ: pulse fmt_err, clear locked, replace the candidate, go to VERIFY.
REQ-030 In any state, the timeout of REQ-002 SHALL force SEARCH, locked=0, with no fmt_err.
REQ-031 locked SHALL be 1 only in LOCKED; it asserts in the same cycle the state enters LOCKED.
REQ-032 A simultaneous HSYNC and VSYNC leading edge SHALL count that line in v_total for the closing frame, then start the new frame.
REQ-033 DE high during VSYNC active SHALL be captured and counted normally; there is no blanking enforcement.

Reset
REQ-034 While RST=1 all outputs SHALL be 0, the FSM SHALL be in SEARCH, and all counters and measurements SHALL be 0.
REQ-035 Reset asserted mid-frame SHALL discard partial measurements; after release, lock SHALL take at least 2 complete frames plus the first VSYNC edge.

Structure
REQ-036 A shared package SHALL hold the lock-state enumeration, the 12-bit counter width, and the RGB565 field widths.
REQ-037 One sub-module, lcd_sync_edge, SHALL perform the input register, polarity normalisation, and leading/falling edge detection.

Verification
REQ-038 Reset: 480x272 active, 525x286 total, active-low syncs; after 3 VSYNC edges: locked=1, h_active=480, h_total=525, v_active=272, v_total=286.
REQ-039 Pixel path: DE high 480 clocks with a ramp on RGB; pix_x runs 0..479, lagging the pins by 2 clocks with matching pix_rgb; pix_y increments per line and reaches 271.
REQ-040 While locked, change h_total to 531: fmt_err pulses once, locked=0, and locked=1 returns after 2 frames at 531.
REQ-041 Stop VSYNC for 2^20 clocks while locked: locked=0, state SEARCH, no fmt_err.
REQ-042 Assert RST mid-line at pix_x=200: all outputs are 0 immediately; after release, lock is regained only after 3 VSYNC edges.
REQ-043 SYNC_ACTIVE_LOW=0 with inverted syncs gives the same results as REQ-038; h_total=5000 saturates at 4095.
